fp_seq_alu: RTL
===============

FP_SEQ_ALU -- requirements
Module: fp_seq_alu

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa width; W = 1+EXP_W+MAN_W (default 16, IEEE half layout).
REQ-003 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  load/execute strobe, sampled on rising edge.
REQ-006 SHALL have port data  input  W  operand or opcode bus, captured on the edge where start=1.
REQ-007 SHALL have port result  output  W  result {sign, exponent, mantissa}.
REQ-008 SHALL have port ready  output  1  result valid.
REQ-009 SHALL have port error  output  1  operation aborted.
REQ-010 SHALL have port err_code  output  2  01 invalid opcode, 10 NaN/Inf operand, 11 overflow.
REQ-011 SHALL have port busy  output  1  high while in EXEC.

Function
REQ-012 SHALL implement states IDLE, LOAD_B, LOAD_OP, ARMED, EXEC, DONE, ERR.
REQ-013 IDLE/DONE/ERR + start: capture data as A, clear ready/error/err_code, go LOAD_B.
REQ-014 LOAD_B + start: capture B, go LOAD_OP; LOAD_OP + start: capture data[1:0] as opcode (upper bits ignored), go ARMED.
REQ-015 ARMED + start (execute strobe, edge N): go EXEC; data ignored.
REQ-016 Without start, load states SHALL hold indefinitely; start in EXEC SHALL be ignored.
REQ-017 Opcodes: 0 = A+B, 1 = A-B, 2 = A*B, 3 = invalid.
REQ-018 Opcode 3 or any operand with exponent all-ones: ERR at edge N+1, error=1, err_code 01 (opcode checked first) or 10.
REQ-019 ADD/SUB: align, add, normalise stages; ready=1 and result valid from edge N+3.
REQ-020 MUL: iterative shift-add over MAN_W+1 bits (hidden bit included), one bit per cycle, then normalise; ready=1 from edge N+MAN_W+4 (N+14 by default).
REQ-021 Operand with exponent 0 SHALL be treated as exact zero (denormals flushed); mantissa ignored.
REQ-022 Rounding SHALL be truncation (toward zero) for all ops.
REQ-023 Biased result exponent >= 2^EXP_W-1: ERR, err_code 11, at the cycle ready would otherwise assert.
REQ-024 Biased result exponent <= 0: result = signed zero, ready=1, no error.
REQ-025 Exact-zero sum SHALL give +0 (0x0000); product sign = signA XOR signB, including zero products.
REQ-026 ready, error, err_code, result SHALL hold until the next accepted start in DONE/ERR; ready and error never high together.
REQ-027 busy=1 exactly in EXEC; ready/error=0 throughout loading and EXEC.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE and clear result, ready, error, err_code, busy to 0, discarding operands and in-flight computation.
REQ-029 start on the same edge as rst=1 SHALL be ignored.

Verification
REQ-030 A=0x3C00, B=0x4000, op=0, execute at edge N -> ready=1 at N+3, result=0x4200, error=0.
REQ-031 A=0x4000, B=0x4200, op=2 -> busy N+1..N+13, ready at N+14, result=0x4600.
REQ-032 A=0x3C00, B=0x3C00, op=1 -> result=0x0000 at N+3; A=0x0001, B=0x8000, op=2 -> result=0x8000.
REQ-033 op=3 -> error=1, err_code=01 at N+1; A=0x7C00, op=0 -> err_code=10; A=0x7BFF, B=0x4000, op=2 -> err_code=11 at N+14.
REQ-034 rst=1 at N+5 during MUL -> all outputs 0 next edge; fresh A/B/op sequence then completes normally.
REQ-035 Parameter run EXP_W=8, MAN_W=23: 1.0+2.0 (0x3F800000+0x40000000) -> 0x40400000 at N+3; 2.0*3.0 -> 0x40C00000 at N+27.

Source files
------------

// File: rtl/fp_seq_alu.sv
// Sequential floating-point ALU: operands and opcode are loaded over one bus, then
// add/sub run as a three-stage pipeline and multiply as an iterative shift-add.
module fp_seq_alu #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] data,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 ready,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int unsigned W        = 1 + EXP_W + MAN_W;
  localparam int unsigned HW       = MAN_W + 1;
  localparam int unsigned SW       = MAN_W + 5;
  localparam int unsigned PW       = 2 * HW;
  localparam int unsigned EW       = EXP_W + 3;
  localparam int unsigned LW       = $clog2(SW);
  localparam int unsigned CW       = $clog2(MAN_W + 4) + 1;
  localparam int unsigned BIAS     = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX     = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EMAX);
  localparam logic signed [EW-1:0] ZERO_S    = '0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_B  = 3'd1;
  localparam logic [2:0] S_LOAD_OP = 3'd2;
  localparam logic [2:0] S_ARMED   = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic [1:0]             op_q, op_d;
  logic [SW-1:0]          x_q, x_d, y_q, y_d, sum_q, sum_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic [PW-1:0]          mcand_q, mcand_d, acc_q, acc_d;
  logic [HW-1:0]          mplier_q, mplier_d;
  logic [MAN_W-1:0]       nman_q, nman_d;
  logic [W-1:0]           result_q, result_d;
  logic                   ready_q, ready_d, error_q, error_d, busy_q, busy_d;
  logic [1:0]             err_code_q, err_code_d;

  // Operand decode; exponent zero flushes to exact zero
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [HW-1:0]    a_sig, b_sig;
  logic             a_zero, b_zero, a_special, b_special, a_sgn, b_sgn_eff, is_mul;

  assign a_exp     = a_q[W-2 -: EXP_W];
  assign b_exp     = b_q[W-2 -: EXP_W];
  assign a_zero    = (a_exp == '0);
  assign b_zero    = (b_exp == '0);
  assign a_sig     = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0]};
  assign b_sig     = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0]};
  assign a_special = &a_exp;
  assign b_special = &b_exp;
  assign a_sgn     = a_q[W-1];
  assign b_sgn_eff = b_q[W-1] ^ (op_q == 2'd1);
  assign is_mul    = (op_q == 2'd2);

  // Alignment: larger magnitude becomes x, smaller is shifted with guard/round/sticky bits
  logic                a_ge;
  logic [EXP_W-1:0]    big_exp, small_exp, diff;
  logic [HW-1:0]       big_sig, small_sig;
  logic [SW-2:0]       small_ext, al_mask, al_y;
  logic                big_sgn, al_sticky;

  always_comb begin
    a_ge      = {a_exp, a_sig} >= {b_exp, b_sig};
    big_exp   = a_ge ? a_exp : b_exp;
    small_exp = a_ge ? b_exp : a_exp;
    big_sig   = a_ge ? a_sig : b_sig;
    small_sig = a_ge ? b_sig : a_sig;
    big_sgn   = a_ge ? a_sgn : b_sgn_eff;
    diff      = big_exp - small_exp;
    small_ext = {small_sig, 3'b000};
    al_mask   = ~({(SW-1){1'b1}} << diff);
    al_sticky = |(small_ext & al_mask);
    al_y      = (small_ext >> diff) | {{(SW-2){1'b0}}, al_sticky};
  end

  // Sum normaliser: carry-out shifts right, cancellation shifts left to the leading one
  logic [LW-1:0]        lead, nshift;
  logic [SW-1:0]        shifted;
  logic signed [EW-1:0] an_exp;
  logic [MAN_W-1:0]     an_man;

  always_comb begin
    lead = '0;
    for (int i = 0; i < int'(SW) - 1; i++) begin
      if (sum_q[i]) lead = LW'(i);
    end
    nshift  = LW'(SW - 2) - lead;
    shifted = sum_q << nshift;
    if (sum_q[SW-1]) begin
      an_exp = exp_q + EW'(1);
      an_man = sum_q[SW-2 -: MAN_W];
    end else begin
      an_exp = exp_q - EW'(nshift);
      an_man = shifted[SW-3 -: MAN_W];
    end
  end

  logic signed [EW-1:0] fin_exp;
  logic [MAN_W-1:0]     fin_man;
  logic                 fin_zero, fin_sign, finish;

  always_comb begin
    if (is_mul) begin
      fin_exp  = exp_q;
      fin_man  = nman_q;
      fin_zero = zero_q;
      fin_sign = sign_q;
    end else begin
      fin_exp  = an_exp;
      fin_man  = an_man;
      fin_zero = (sum_q == '0);
      fin_sign = (sum_q == '0) ? 1'b0 : sign_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    sum_d      = sum_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    zero_d     = zero_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    nman_d     = nman_q;
    result_d   = result_q;
    ready_d    = ready_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    busy_d     = busy_q;
    finish     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          a_d        = data;
          ready_d    = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'b00;
          state_d    = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (start) begin
          b_d     = data;
          state_d = S_LOAD_OP;
        end
      end
      S_LOAD_OP: begin
        if (start) begin
          op_d    = data[1:0];
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (start) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          if (op_q == 2'd3) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'b01;
            busy_d     = 1'b0;
          end else if (a_special || b_special) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'b10;
            busy_d     = 1'b0;
          end else if (is_mul) begin
            mcand_d  = PW'(a_sig);
            mplier_d = b_sig;
            acc_d    = '0;
            exp_d    = EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
            sign_d   = a_sgn ^ b_q[W-1];
            zero_d   = a_zero || b_zero;
          end else begin
            x_d    = {1'b0, big_sig, 3'b000};
            y_d    = {1'b0, al_y};
            exp_d  = EW'(big_exp);
            sign_d = big_sgn;
            sub_d  = a_sgn ^ b_sgn_eff;
          end
        end else if (!is_mul) begin
          if (cnt_q == CW'(1)) begin
            sum_d = sub_q ? (x_q - y_q) : (x_q + y_q);
          end else begin
            finish = 1'b1;
          end
        end else if (cnt_q <= CW'(MAN_W + 1)) begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else if (cnt_q == CW'(MAN_W + 2)) begin
          if (acc_q[PW-1]) begin
            nman_d = acc_q[PW-2 -: MAN_W];
            exp_d  = exp_q + EW'(1);
          end else begin
            nman_d = acc_q[PW-3 -: MAN_W];
          end
        end else begin
          finish = 1'b1;
        end

        // Final cycle: underflow flushes to signed zero, overflow aborts
        if (finish) begin
          busy_d = 1'b0;
          if (fin_zero || (fin_exp <= ZERO_S)) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = {fin_sign, {(W-1){1'b0}}};
          end else if (fin_exp >= EXP_MAX_S) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = 2'b11;
          end else begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = {fin_sign, fin_exp[EXP_W-1:0], fin_man};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zero_q     <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      nman_q     <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      zero_q     <= zero_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      nman_q     <= nman_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;

endmodule
